exe_muldiv_iter: RTL and testbench

- Iterative RV64M multiply/divide unit, parametrised in XLEN, alongside the single-cycle execute ALU.
- Takes already-forwarded operands from the execute stage through a valid/ready handshake.
- Runs a shift-add multiply or a restoring divide, one bit per cycle.
- Holds the result until writeback accepts it. Supports 32-bit W variants and a pipeline flush.

---
 rtl/exe_muldiv_iter_if.sv | 27 ++
 rtl/exe_muldiv_iter.sv | 189 ++++++++++++++++++
 tb/tb_exe_muldiv_iter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_iter_if.sv
// Handshake bundle between the execute stage, the iterative mul/div unit and writeback.
// The execute/writeback side uses the master modport, the unit uses slave.
interface exe_muldiv_iter_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/exe_muldiv_iter.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// with W variants, divide special-case bypass and a flush that kills in-flight or held ops.
module exe_muldiv_iter #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  exe_muldiv_iter_if.slave io
);
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [31:0] neg_32(input logic [31:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic               out_valid_q, out_valid_d;

  logic            op_w, op_div, legal, sgn_a, sgn_b, div0, ovf, special, accept;
  logic [1:0]      sub;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_w, spec_res;

  // Request decode: operand magnitudes, sign flags and the single-cycle special cases.
  always_comb begin
    op_w   = io.in_op[3];
    op_div = io.in_op[2];
    sub    = io.in_op[1:0];
    legal  = !(op_w && !op_div && sub != 2'd0) && !(XLEN == 32 && op_w);
    sgn_a  = op_div ? !sub[0] : (!op_w && sub != 2'd3);
    sgn_b  = op_div ? !sub[0] : (!op_w && !sub[1]);
    a_ext  = op_w ? (sgn_a ? sext32(io.in_rs1[31:0]) : XLEN'(io.in_rs1[31:0])) : io.in_rs1;
    b_ext  = op_w ? (sgn_b ? sext32(io.in_rs2[31:0]) : XLEN'(io.in_rs2[31:0])) : io.in_rs2;
    a_mag  = abs_if(a_ext, sgn_a);
    b_mag  = abs_if(b_ext, sgn_b);
    div0   = (b_ext == '0);
    ovf    = sgn_a && (op_w ? (io.in_rs1[31:0] == 32'h8000_0000 && io.in_rs2[31:0] == 32'hFFFF_FFFF)
                            : (io.in_rs1 == MIN && io.in_rs2 == '1));
    special = !legal || (op_div && (div0 || ovf));
    dvd_w   = op_w ? sext32(io.in_rs1[31:0]) : io.in_rs1;
    if (!legal)     spec_res = '0;
    else if (div0)  spec_res = sub[1] ? dvd_w : '1;
    else            spec_res = sub[1] ? '0 : dvd_w;
    accept = io.in_valid && !flush && (state_q == IDLE);
  end

  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [31:0]       q32, r32;
  logic [XLEN-1:0]   fin_res;
  logic [CNT_W-1:0]  n_iter;

  // One iteration step, plus the sign correction and result select used on the final edge.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    trial    = rem_sh[XLEN-1:0] - opnd_q;
    div_next = (rem_sh >= {1'b0, opnd_q}) ? {trial, acc_q[XLEN-2:0], 1'b1}
                                          : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod = neg_2x(acc_q, neg_q);
    q32  = neg_32(acc_q[31:0], neg_q);
    r32  = neg_32(acc_q[XLEN+31:XLEN], neg_q);
    case ({op_q[3], op_q[2]})
      2'b00:   fin_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      // a 32-bit multiplier leaves the product shifted up by XLEN-32
      2'b10:   fin_res = sext32(acc_q[XLEN-1 -: 32]);
      2'b01:   fin_res = neg_x(op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0], neg_q);
      default: fin_res = sext32(op_q[1] ? r32 : q32);
    endcase
    n_iter = op_q[3] ? CNT_W'(32) : CNT_W'(XLEN);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = io.in_op;
          tag_d  = io.in_tag;
          cnt_d  = '0;
          opnd_d = op_div ? b_mag : a_mag;
          neg_d  = (op_div && sub[1]) ? (sgn_a && a_ext[XLEN-1])
                                      : ((sgn_a && a_ext[XLEN-1]) ^ (sgn_b && b_ext[XLEN-1]));
          // W dividends start in the top half so their bits reach the remainder first
          if (op_div) acc_d = {{XLEN{1'b0}}, op_w ? (a_mag << 32) : a_mag};
          else        acc_d = {{XLEN{1'b0}}, b_mag};
          if (special) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == n_iter) begin
          res_d       = fin_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // special cases enter DONE directly and raise valid one edge later
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready   = (state_q == IDLE);
  assign io.out_valid  = out_valid_q;
  assign io.out_result = res_q;
  assign io.out_tag    = tag_q;
endmodule

// File: tb/tb_exe_muldiv_iter.sv
// Scoreboard bench for exe_muldiv_iter: driver pushes reference results, monitor pops and compares.
module tb_exe_muldiv_iter;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  exe_muldiv_iter_if #(.XLEN(64), .TAG_W(5)) bus ();
  exe_muldiv_iter #(.XLEN(64), .TAG_W(5)) dut (.clk(clk), .rst(rst), .flush(flush), .io(bus));

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   first_seen = 0;
  bit   mon_off = 0;
  bit   rdy_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: plain wide arithmetic following the RISC-V M-extension rules.
  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0] pu;
    logic [31:0] a32, b32, t32;
    logic [63:0] r;
    logic ovf64, ovf32;
    a32 = a[31:0];
    b32 = b[31:0];
    ovf64 = (a == MIN64) && (b == ONES);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
      4'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
      4'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
      4'd4: if (b == 0) r = ONES; else if (ovf64) r = a; else r = $signed(a) / $signed(b);
      4'd5: if (b == 0) r = ONES; else r = a / b;
      4'd6: if (b == 0) r = a; else if (ovf64) r = '0; else r = $signed(a) % $signed(b);
      4'd7: if (b == 0) r = a; else r = a % b;
      4'd8: begin t32 = a32 * b32; r = sx(t32); end
      4'd12: if (b32 == 0) r = ONES; else if (ovf32) r = sx(a32);
             else begin t32 = $signed(a32) / $signed(b32); r = sx(t32); end
      4'd13: if (b32 == 0) r = ONES; else begin t32 = a32 / b32; r = sx(t32); end
      4'd14: if (b32 == 0) r = sx(a32); else if (ovf32) r = '0;
             else begin t32 = $signed(a32) % $signed(b32); r = sx(t32); end
      4'd15: if (b32 == 0) r = sx(a32); else begin t32 = a32 % b32; r = sx(t32); end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op >= 4'd9 && op <= 4'd11) return 1;
    if (op[2]) begin
      if (op[3] && (b[31:0] == 0 || (op[0] == 1'b0 && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))) return 1;
      if (!op[3] && (b == 0 || (op[0] == 1'b0 && a == MIN64 && b == ONES))) return 1;
    end
    return op[3] ? 33 : 65;
  endfunction

  // Monitor: compares every presented output against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && !mon_off && bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        chk("result", bus.out_result, sbq[0].res);
        chk("tag", {59'd0, bus.out_tag}, {59'd0, sbq[0].tag});
        chk("in_ready_while_valid", {63'd0, bus.in_ready}, 64'd0);
        if (!first_seen) begin
          chk("latency_cycle", 64'(cyc), 64'(sbq[0].due));
          first_seen = 1;
        end
        if (bus.out_ready) begin
          void'(sbq.pop_front());
          first_seen = 0;
        end
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input bit push);
    int w;
    exp_t e;
    w = 0;
    while (!bus.in_ready && w < 400) begin
      step();
      w++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    step();
    bus.in_valid = 1'b0;
    if (push) begin
      e.res = model_res(op, a, b);
      e.tag = tag;
      e.due = cyc + model_lat(op, a, b);
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 400) begin
      step();
      w++;
    end
    chk("drain_scoreboard_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!bus.out_valid && w < 200) begin
      step();
      w++;
    end
    chk("out_valid_timeout", {63'd0, bus.out_valid}, 64'd1);
  endtask

  function automatic logic [63:0] rnd_opnd();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = MIN64;
      2: v = ONES;
      3: v = 64'($urandom_range(0, 20));
      4: v = -64'($urandom_range(1, 20));
      5: v = {$urandom(), 32'h8000_0000 | 32'($urandom_range(0, 3))};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  logic [3:0]  d_op  [16] = '{4'd0, 4'd3, 4'd1, 4'd4, 4'd6, 4'd12, 4'd5, 4'd7,
                              4'd4, 4'd6, 4'd14, 4'd9, 4'd2, 4'd8, 4'd15, 4'd13};
  logic [63:0] d_a   [16] = '{64'd7, ONES, ONES, -64'd7, -64'd7, 64'h1_0000_0007, 64'd5, 64'd5,
                              MIN64, MIN64, 64'h8000_0000, 64'd1, ONES, 64'hFFFF_FFFF,
                              64'h8000_0005, 64'hFFFF_FFFF};
  logic [63:0] d_b   [16] = '{-64'd3, ONES, ONES, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0,
                              ONES, ONES, 64'hFFFF_FFFF, 64'd2, 64'd2, 64'd2, 64'd0, 64'd1};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_out_result", bus.out_result, 64'd0);
    chk("reset_out_tag", {59'd0, bus.out_tag}, 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) issue(d_op[i], d_a[i], d_b[i], 5'(i + 3), 1'b1);
    drain();

    // Output hold under backpressure.
    bus.out_ready = 1'b0;
    issue(4'd0, 64'd123456789, 64'd987654321, 5'd21, 1'b1);
    wait_valid();
    repeat (10) step();
    chk("hold_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("in_ready_after_accept", {63'd0, bus.in_ready}, 64'd1);

    rdy_rand = 1;
    for (int i = 0; i < 40; i++) issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), 1'b1);
    rdy_rand = 0;
    bus.out_ready = 1'b1;
    step();
    drain();

    // Flush mid-CALC: nothing may come out.
    issue(4'd0, 64'd11, 64'd13, 5'd1, 1'b0);
    repeat (20) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    repeat (70) step();
    chk("flush_no_late_valid", {63'd0, bus.out_valid}, 64'd0);

    // A request alongside flush is dropped.
    bus.in_valid = 1'b1;
    bus.in_op = 4'd5;
    bus.in_rs1 = 64'd5;
    bus.in_rs2 = 64'd0;
    flush = 1'b1;
    step();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_not_taken", {63'd0, bus.in_ready}, 64'd1);
    repeat (3) step();
    chk("flush_req_no_valid", {63'd0, bus.out_valid}, 64'd0);

    // Async reset mid-CALC.
    issue(4'd4, 64'd1000, 64'd7, 5'd9, 1'b0);
    repeat (30) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
    step();
    rst = 1'b0;
    step();
    issue(4'd0, 64'd3, 64'd4, 5'd30, 1'b1);
    drain();

    // Flush in DONE discards the held result even with out_ready high.
    mon_off = 1;
    bus.out_ready = 1'b0;
    issue(4'd5, 64'd9, 64'd0, 5'd2, 1'b0);
    wait_valid();
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_done_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_done_in_ready", {63'd0, bus.in_ready}, 64'd1);
    repeat (3) step();
    chk("flush_done_stays_idle", {63'd0, bus.out_valid}, 64'd0);
    mon_off = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
